// File: rtl/tft_spi_tx.sv
// SPI mode-0 byte transmitter for a TFT panel: one 8-bit byte plus D/C flag per transfer, MSB first.
// Latency: acceptance edge ends cycle 0; first SCLK rise after HALF_PERIOD+1 cycles; busy for 16*HALF_PERIOD cycles.
// Backpressure: strobes offered while tft_busy=1 are dropped; a held strobe is re-accepted in the completion cycle.
module tft_spi_tx #(
  parameter int unsigned HALF_PERIOD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tft_transmit,
  input  logic       tft_dc,
  input  logic [7:0] tft_data,
  output logic       tft_busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       spi_dc
);

  localparam int unsigned CW = $clog2(HALF_PERIOD + 1);
  localparam logic [CW-1:0] HP_RELOAD = CW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] hp_cnt_q, hp_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        dc_q, dc_d;
  logic [2:0]  bit_nxt;

  assign bit_nxt = bit_cnt_q - 3'd1;

  // Next-state and registered-output logic; every output is decided one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_d   = state_q;
    hp_cnt_d  = hp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    busy_d    = busy_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    dc_d      = dc_q;

    case (state_q)
      IDLE: begin
        // mosi and dc keep their last values between bytes
        if (tft_transmit && !busy_q) begin
          state_d   = SHIFT_LO;
          hp_cnt_d  = HP_RELOAD;
          bit_cnt_d = 3'd7;
          data_d    = tft_data;
          dc_d      = tft_dc;
          mosi_d    = tft_data[7];
          sclk_d    = 1'b0;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end

      SHIFT_LO: begin
        if (hp_cnt_q == '0) begin
          state_d  = SHIFT_HI;
          hp_cnt_d = HP_RELOAD;
          sclk_d   = 1'b1;
        end else begin
          hp_cnt_d = hp_cnt_q - CW'(1);
        end
      end

      SHIFT_HI: begin
        if (hp_cnt_q == '0) begin
          sclk_d = 1'b0;
          if (bit_cnt_q != 3'd0) begin
            // falling SCLK edge: the only point where mosi moves
            state_d   = SHIFT_LO;
            hp_cnt_d  = HP_RELOAD;
            bit_cnt_d = bit_nxt;
            mosi_d    = data_q[bit_nxt];
          end else begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          hp_cnt_d = hp_cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hp_cnt_q  <= '0;
      bit_cnt_q <= 3'd0;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      dc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_cnt_q  <= hp_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      dc_q      <= dc_d;
    end
  end

  assign tft_busy = busy_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;
  assign spi_dc   = dc_q;

endmodule

// File: tb/tb_tft_spi_tx.sv
// Directed bench for tft_spi_tx: two instances (HALF_PERIOD 1 and 3) and an SPI-slave style monitor.
// Stimulus and checks run at negedge+1; the monitor samples pins at each negedge.
// Expected bytes, timings and counts are written out by hand from the intended behaviour.
module tb_tft_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       rst = 1'b1;
  logic       a_tx = 1'b0, a_dc = 1'b0, b_tx = 1'b0, b_dc = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_busy, a_sclk, a_mosi, a_csn, a_spidc;
  logic       b_busy, b_sclk, b_mosi, b_csn, b_spidc;

  tft_spi_tx #(.HALF_PERIOD(1)) dut_a (
    .clk(clk), .rst(rst), .tft_transmit(a_tx), .tft_dc(a_dc), .tft_data(a_data),
    .tft_busy(a_busy), .spi_sclk(a_sclk), .spi_mosi(a_mosi), .spi_cs_n(a_csn), .spi_dc(a_spidc)
  );

  tft_spi_tx #(.HALF_PERIOD(3)) dut_b (
    .clk(clk), .rst(rst), .tft_transmit(b_tx), .tft_dc(b_dc), .tft_data(b_data),
    .tft_busy(b_busy), .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_cs_n(b_csn), .spi_dc(b_spidc)
  );

  wire [1:0] sclk_w = {b_sclk, a_sclk};
  wire [1:0] cs_w   = {b_csn, a_csn};
  wire [1:0] mosi_w = {b_mosi, a_mosi};
  wire [1:0] dc_w   = {b_spidc, a_spidc};
  wire [1:0] busy_w = {b_busy, a_busy};

  // SPI slave monitor state (cumulative; the stimulus works with deltas)
  logic [1:0] sclk_p = 2'b00, cs_p = 2'b11, mosi_p = 2'b00, dc_p = 2'b00;
  logic [7:0] shreg[2]       = '{8'h00, 8'h00};
  logic [8:0] last_frame[2]  = '{9'h000, 9'h000};
  int nbits[2]       = '{0, 0};
  int last_nbits[2]  = '{0, 0};
  int rises[2]       = '{0, 0};
  int dc_chg[2]      = '{0, 0};
  int mosi_hi_chg[2] = '{0, 0};
  int busy_cyc[2]    = '{0, 0};
  int frames[2]      = '{0, 0};
  int gap_run[2]     = '{0, 0};
  int last_gap[2]    = '{0, 0};
  int run[2]         = '{0, 0};
  int phase_cnt[2]   = '{0, 0};
  int phase_bad[2]   = '{0, 0};
  logic [8:0] rxq[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy_w[i]) busy_cyc[i] <= busy_cyc[i] + 1;
      if (!cs_w[i]) begin
        if (sclk_w[i] && !sclk_p[i]) begin
          shreg[i] <= {shreg[i][6:0], mosi_w[i]};
          nbits[i] <= nbits[i] + 1;
          rises[i] <= rises[i] + 1;
        end
        if (sclk_w[i] && sclk_p[i] && (mosi_w[i] != mosi_p[i])) mosi_hi_chg[i] <= mosi_hi_chg[i] + 1;
        if (!cs_p[i] && (dc_w[i] != dc_p[i])) dc_chg[i] <= dc_chg[i] + 1;
        if (cs_p[i]) begin
          run[i]      <= 1;
          last_gap[i] <= gap_run[i];
        end else if (sclk_w[i] == sclk_p[i]) begin
          run[i] <= run[i] + 1;
        end else begin
          phase_cnt[i] <= phase_cnt[i] + 1;
          if (run[i] != ((i == 0) ? 1 : 3)) phase_bad[i] <= phase_bad[i] + 1;
          run[i] <= 1;
        end
        gap_run[i] <= 0;
      end else begin
        if (sclk_w[i] && !sclk_p[i]) rises[i] <= rises[i] + 1;
        if (!cs_p[i]) begin
          phase_cnt[i] <= phase_cnt[i] + 1;
          if (run[i] != ((i == 0) ? 1 : 3)) phase_bad[i] <= phase_bad[i] + 1;
          last_frame[i] <= {dc_p[i], shreg[i]};
          last_nbits[i] <= nbits[i];
          nbits[i]      <= 0;
          frames[i]     <= frames[i] + 1;
          if (i == 0) rxq.push_back({dc_p[i], shreg[i]});
          gap_run[i] <= 1;
        end else begin
          gap_run[i] <= gap_run[i] + 1;
        end
      end
    end
    sclk_p <= sclk_w;
    cs_p   <= cs_w;
    mosi_p <= mosi_w;
    dc_p   <= dc_w;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  logic [8:0] stream[19] = '{
    9'h02A, 9'h100, 9'h100, 9'h100, 9'h17F, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h19F, 9'h02C,
    9'h1F8, 9'h100, 9'h107, 9'h1E0, 9'h1FF, 9'h1FF, 9'h100, 9'h11F
  };

  initial begin
    int s_fr, s_busy, s_dc, s_mh, s_pb, s_pc, s_rise, qbase, idx;
    logic acc;

    // reset
    step(2);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_sclk", 32'(a_sclk), 32'd0);
    chk("rst_cs_n", 32'(a_csn), 32'd1);
    chk("rst_mosi", 32'(a_mosi), 32'd0);
    chk("rst_dc",   32'(a_spidc), 32'd0);
    rst = 1'b0;
    step(2);

    // HALF_PERIOD=1, single pulse, dc=0, A5
    s_fr = frames[0]; s_busy = busy_cyc[0]; s_dc = dc_chg[0]; s_mh = mosi_hi_chg[0];
    s_pb = phase_bad[0]; s_pc = phase_cnt[0];
    a_tx = 1'b1; a_dc = 1'b0; a_data = 8'hA5;
    step(1);
    a_tx = 1'b0;
    chk("a5_c1_busy", 32'(a_busy), 32'd1);
    chk("a5_c1_cs_n", 32'(a_csn), 32'd0);
    chk("a5_c1_sclk", 32'(a_sclk), 32'd0);
    chk("a5_c1_mosi", 32'(a_mosi), 32'd1);
    step(15);
    chk("a5_c16_sclk", 32'(a_sclk), 32'd1);
    step(1);
    chk("a5_c17_busy", 32'(a_busy), 32'd0);
    chk("a5_c17_cs_n", 32'(a_csn), 32'd1);
    chk("a5_c17_sclk", 32'(a_sclk), 32'd0);
    step(5);
    chk("a5_frames",   32'(frames[0] - s_fr), 32'd1);
    chk("a5_byte",     32'(last_frame[0]), 32'h0A5);
    chk("a5_nbits",    32'(last_nbits[0]), 32'd8);
    chk("a5_busy_len", 32'(busy_cyc[0] - s_busy), 32'd16);
    chk("a5_dc_const", 32'(dc_chg[0] - s_dc), 32'd0);
    chk("a5_mosi_hi",  32'(mosi_hi_chg[0] - s_mh), 32'd0);
    chk("a5_phases",   32'(phase_cnt[0] - s_pc), 32'd16);
    chk("a5_phase_len", 32'(phase_bad[0] - s_pb), 32'd0);
    chk("a5_idle_mosi", 32'(a_mosi), 32'd1);

    // HALF_PERIOD=3, dc=1, 3C
    s_fr = frames[1]; s_busy = busy_cyc[1]; s_pb = phase_bad[1]; s_pc = phase_cnt[1]; s_mh = mosi_hi_chg[1];
    b_tx = 1'b1; b_dc = 1'b1; b_data = 8'h3C;
    step(1);
    b_tx = 1'b0;
    step(55);
    chk("3c_frames",    32'(frames[1] - s_fr), 32'd1);
    chk("3c_byte",      32'(last_frame[1]), 32'h13C);
    chk("3c_busy_len",  32'(busy_cyc[1] - s_busy), 32'd48);
    chk("3c_phases",    32'(phase_cnt[1] - s_pc), 32'd16);
    chk("3c_phase_len", 32'(phase_bad[1] - s_pb), 32'd0);
    chk("3c_mosi_hi",   32'(mosi_hi_chg[1] - s_mh), 32'd0);
    chk("3c_idle_dc",   32'(b_spidc), 32'd1);

    // back-to-back: 2A dc=0, then 00 dc=1 strobed in the completion cycle
    qbase = rxq.size(); s_dc = dc_chg[0];
    a_tx = 1'b1; a_dc = 1'b0; a_data = 8'h2A;
    step(1);
    a_tx = 1'b0;
    step(16);
    chk("b2b_c17_busy", 32'(a_busy), 32'd0);
    a_tx = 1'b1; a_dc = 1'b1; a_data = 8'h00;
    step(1);
    a_tx = 1'b0;
    chk("b2b_2nd_cs_n", 32'(a_csn), 32'd0);
    step(20);
    chk("b2b_count", 32'(rxq.size() - qbase), 32'd2);
    chk("b2b_byte0", (qbase < rxq.size()) ? 32'(rxq[qbase]) : 32'hDEAD, 32'h02A);
    chk("b2b_byte1", (qbase + 1 < rxq.size()) ? 32'(rxq[qbase + 1]) : 32'hDEAD, 32'h100);
    chk("b2b_gap", 32'(last_gap[0]), 32'd1);
    chk("b2b_dc_const", 32'(dc_chg[0] - s_dc), 32'd0);

    // strobe with FF at cycle 5 of a busy 00 transfer is dropped
    s_fr = frames[0]; s_rise = rises[0];
    a_tx = 1'b1; a_dc = 1'b0; a_data = 8'h00;
    step(1);
    a_tx = 1'b0;
    step(4);
    a_tx = 1'b1; a_data = 8'hFF;
    step(1);
    a_tx = 1'b0;
    chk("ign_c6_busy", 32'(a_busy), 32'd1);
    step(30);
    chk("ign_frames", 32'(frames[0] - s_fr), 32'd1);
    chk("ign_byte",   32'(last_frame[0]), 32'h000);
    chk("ign_rises",  32'(rises[0] - s_rise), 32'd8);
    chk("ign_busy",   32'(a_busy), 32'd0);

    // reset at cycle 7 of an FF/dc=1 transfer
    a_tx = 1'b1; a_dc = 1'b1; a_data = 8'hFF;
    step(1);
    a_tx = 1'b0;
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mrst_sclk", 32'(a_sclk), 32'd0);
    chk("mrst_cs_n", 32'(a_csn), 32'd1);
    chk("mrst_busy", 32'(a_busy), 32'd0);
    chk("mrst_mosi", 32'(a_mosi), 32'd0);
    chk("mrst_dc",   32'(a_spidc), 32'd0);
    s_rise = rises[0];
    step(20);
    chk("mrst_no_sclk", 32'(rises[0] - s_rise), 32'd0);

    // reset wins over a simultaneous strobe
    rst = 1'b1; a_tx = 1'b1; a_dc = 1'b1; a_data = 8'hFF;
    step(1);
    rst = 1'b0; a_tx = 1'b0;
    chk("rprio_busy", 32'(a_busy), 32'd0);
    chk("rprio_cs_n", 32'(a_csn), 32'd1);
    step(10);
    chk("rprio_no_sclk", 32'(rises[0] - s_rise), 32'd0);

    // upstream writer: 11 setup bytes then pixels, strobe held, advance on acceptance
    qbase = rxq.size();
    idx = 0;
    for (int c = 0; c < 1000 && idx < 19; c++) begin
      step(1);
      a_tx = 1'b1; a_dc = stream[idx][8]; a_data = stream[idx][7:0];
      acc = !a_busy;
      @(posedge clk);
      if (acc) idx++;
    end
    step(1);
    a_tx = 1'b0;
    chk("strm_sent", 32'(idx), 32'd19);
    step(25);
    chk("strm_count", 32'(rxq.size() - qbase), 32'd19);
    for (int k = 0; k < 19; k++) begin
      chk($sformatf("strm_byte%0d", k),
          (qbase + k < rxq.size()) ? 32'(rxq[qbase + k]) : 32'hDEAD, 32'(stream[k]));
    end
    chk("strm_gap", 32'(last_gap[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
